// File: rtl/voice_alloc_if.sv
// Note-strobe / voice-output bundle between the MIDI decoder
// and the voice allocator.
interface voice_alloc_if #(
  parameter int VOICES = 4,
  parameter int NOTE_W = 8
);
  localparam int CNT_W = $clog2(VOICES + 1);

  logic [NOTE_W-1:0]        note_i;
  logic                     noteOnStrb_i;
  logic                     noteOffStrb_i;
  logic [VOICES*NOTE_W-1:0] voiceNote_o;
  logic [VOICES-1:0]        voiceGate_o;
  logic [VOICES-1:0]        voiceLoad_o;
  logic                     steal_o;
  logic [CNT_W-1:0]         activeCnt_o;

  modport master (
    output note_i, noteOnStrb_i, noteOffStrb_i,
    input  voiceNote_o, voiceGate_o, voiceLoad_o,
    input  steal_o, activeCnt_o
  );

  modport slave (
    input  note_i, noteOnStrb_i, noteOffStrb_i,
    output voiceNote_o, voiceGate_o, voiceLoad_o,
    output steal_o, activeCnt_o
  );
endinterface

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: free-slot allocation, retrigger,
// LRU stealing and note-off release onto VOICES oscillators.
module voice_alloc #(
  parameter int VOICES = 4,
  parameter int NOTE_W = 8
) (
  input logic          clk_i,
  input logic          nrst_i,
  voice_alloc_if.slave bus
);
  localparam int AGE_W = $clog2(VOICES);
  localparam int CNT_W = $clog2(VOICES + 1);
  typedef logic [AGE_W-1:0] idx_t;

  logic [NOTE_W-1:0] note [VOICES];
  idx_t              age  [VOICES];
  logic [VOICES-1:0] gate;
  logic [VOICES-1:0] gateNxt;
  logic [VOICES-1:0] load;
  logic              steal;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cntNxt;

  logic onHit, freeHit, offHit;
  idx_t onIdx, freeIdx, oldIdx, offIdx, tgt;
  logic doOn, doOff, doSteal;

  always_comb begin
    onHit   = 1'b0;
    freeHit = 1'b0;
    offHit  = 1'b0;
    onIdx   = '0;
    freeIdx = '0;
    oldIdx  = '0;
    offIdx  = '0;
    for (int v = 0; v < VOICES; v++) begin
      if (!onHit && gate[v] &&
          note[v] == bus.note_i) begin
        onHit = 1'b1;
        onIdx = idx_t'(v);
      end
      if (!freeHit && !gate[v]) begin
        freeHit = 1'b1;
        freeIdx = idx_t'(v);
      end
      if (age[v] == idx_t'(VOICES - 1))
        oldIdx = idx_t'(v);
    end
    // Same-note search doubles as the note-off match.
    offHit  = onHit;
    offIdx  = onIdx;
    doSteal = !onHit && !freeHit;
    tgt     = onHit   ? onIdx   :
              freeHit ? freeIdx : oldIdx;
    doOn    = bus.noteOnStrb_i;
    doOff   = bus.noteOffStrb_i &&
              !bus.noteOnStrb_i && offHit;

    gateNxt = gate;
    if (doOn)
      gateNxt[tgt] = 1'b1;
    else if (doOff)
      gateNxt[offIdx] = 1'b0;

    cntNxt = '0;
    for (int v = 0; v < VOICES; v++)
      cntNxt = cntNxt + CNT_W'(gateNxt[v]);
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int v = 0; v < VOICES; v++) begin
        note[v] <= '0;
        age[v]  <= idx_t'(v);
      end
      gate  <= '0;
      load  <= '0;
      steal <= 1'b0;
      cnt   <= '0;
    end else begin
      load  <= '0;
      steal <= 1'b0;
      gate  <= gateNxt;
      cnt   <= cntNxt;
      if (doOn) begin
        note[tgt] <= bus.note_i;
        load      <= VOICES'(1) << tgt;
        steal     <= doSteal;
        for (int v = 0; v < VOICES; v++)
          if (age[v] < age[tgt])
            age[v] <= age[v] + idx_t'(1);
        age[tgt] <= '0;
      end
    end
  end

  for (genvar v = 0; v < VOICES; v++) begin : gNote
    assign bus.voiceNote_o[v*NOTE_W +: NOTE_W] = note[v];
  end

  assign bus.voiceGate_o = gate;
  assign bus.voiceLoad_o = load;
  assign bus.steal_o     = steal;
  assign bus.activeCnt_o = cnt;
endmodule

// File: tb/tb_voice_alloc.sv
// Directed self-checking bench for voice_alloc (VOICES=4).
// Expected values are hand-derived from the allocation rules.
module tb_voice_alloc;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  voice_alloc_if #(.VOICES(4), .NOTE_W(8)) bus ();

  voice_alloc #(.VOICES(4), .NOTE_W(8)) dut (
    .clk_i  (clk),
    .nrst_i (rstN),
    .bus    (bus)
  );

  function automatic logic [7:0] vn(input int v);
    logic [31:0] flat;
    flat = bus.voiceNote_o;
    return flat[v*8 +: 8];
  endfunction

  task automatic noteOn(input logic [7:0] n);
    @(negedge clk);
    bus.note_i = n;
    bus.noteOnStrb_i = 1'b1;
    @(negedge clk);
    bus.noteOnStrb_i = 1'b0;
  endtask

  task automatic noteOff(input logic [7:0] n);
    @(negedge clk);
    bus.note_i = n;
    bus.noteOffStrb_i = 1'b1;
    @(negedge clk);
    bus.noteOffStrb_i = 1'b0;
  endtask

  task automatic test_reset;
    bus.note_i = '0;
    bus.noteOnStrb_i = 1'b0;
    bus.noteOffStrb_i = 1'b0;
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.voiceGate_o !== 4'b0 || bus.voiceLoad_o !== 4'b0 ||
        bus.steal_o !== 1'b0 || bus.activeCnt_o !== 3'd0 ||
        bus.voiceNote_o !== 32'h0) begin
      $display("FAIL reset: gate=%b load=%b steal=%b cnt=%0d notes=%h (want all 0)",
               bus.voiceGate_o, bus.voiceLoad_o, bus.steal_o,
               bus.activeCnt_o, bus.voiceNote_o);
      errors++;
    end
    rstN = 1'b1;
  endtask

  task automatic test_alloc;
    logic [3:0] expLoad [3];
    logic [7:0] ns [3];
    ns = '{8'd60, 8'd64, 8'd67};
    expLoad = '{4'b0001, 4'b0010, 4'b0100};
    for (int i = 0; i < 3; i++) begin
      noteOn(ns[i]);
      checks++;
      if (bus.voiceLoad_o !== expLoad[i] || bus.steal_o !== 1'b0 ||
          vn(i) !== ns[i]) begin
        $display("FAIL alloc%0d: load=%b steal=%b note=%0d (want %b 0 %0d)",
                 i, bus.voiceLoad_o, bus.steal_o, vn(i), expLoad[i], ns[i]);
        errors++;
      end
    end
    checks++;
    if (bus.voiceGate_o !== 4'b0111 || bus.activeCnt_o !== 3'd3) begin
      $display("FAIL alloc_gate: gate=%b cnt=%0d (want 0111 3)",
               bus.voiceGate_o, bus.activeCnt_o);
      errors++;
    end
  endtask

  task automatic test_retrigger;
    noteOn(8'd64);
    checks++;
    if (bus.voiceLoad_o !== 4'b0010 || bus.voiceGate_o !== 4'b0111 ||
        bus.steal_o !== 1'b0 || bus.activeCnt_o !== 3'd3) begin
      $display("FAIL retrig: load=%b gate=%b steal=%b cnt=%0d (want 0010 0111 0 3)",
               bus.voiceLoad_o, bus.voiceGate_o, bus.steal_o, bus.activeCnt_o);
      errors++;
    end
    noteOn(8'd65);
    noteOn(8'd71);
    checks++;
    if (bus.voiceLoad_o !== 4'b0001 || bus.steal_o !== 1'b1 ||
        vn(0) !== 8'd71) begin
      $display("FAIL retrig_steal1: load=%b steal=%b v0=%0d (want 0001 1 71)",
               bus.voiceLoad_o, bus.steal_o, vn(0));
      errors++;
    end
    // v1 was refreshed by the retrigger, so v2 is now the oldest.
    noteOn(8'd72);
    checks++;
    if (bus.voiceLoad_o !== 4'b0100 || bus.steal_o !== 1'b1 ||
        vn(2) !== 8'd72 || vn(1) !== 8'd64) begin
      $display("FAIL retrig_lru: load=%b steal=%b v2=%0d v1=%0d (want 0100 1 72 64)",
               bus.voiceLoad_o, bus.steal_o, vn(2), vn(1));
      errors++;
    end
  endtask

  task automatic test_steal;
    noteOn(8'd60);
    noteOn(8'd62);
    noteOn(8'd64);
    noteOn(8'd65);
    checks++;
    if (bus.voiceGate_o !== 4'b1111 || bus.activeCnt_o !== 3'd4 ||
        bus.steal_o !== 1'b0) begin
      $display("FAIL fill: gate=%b cnt=%0d steal=%b (want 1111 4 0)",
               bus.voiceGate_o, bus.activeCnt_o, bus.steal_o);
      errors++;
    end
    noteOn(8'd67);
    checks++;
    if (bus.voiceLoad_o !== 4'b0001 || bus.steal_o !== 1'b1 ||
        vn(0) !== 8'd67 || bus.activeCnt_o !== 3'd4) begin
      $display("FAIL steal: load=%b steal=%b v0=%0d cnt=%0d (want 0001 1 67 4)",
               bus.voiceLoad_o, bus.steal_o, vn(0), bus.activeCnt_o);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (bus.steal_o !== 1'b0 || bus.voiceLoad_o !== 4'b0) begin
      $display("FAIL steal_pulse: steal=%b load=%b (want 0 0000)",
               bus.steal_o, bus.voiceLoad_o);
      errors++;
    end
  endtask

  task automatic test_release;
    noteOff(8'd62);
    checks++;
    if (bus.voiceGate_o !== 4'b1101 || bus.activeCnt_o !== 3'd3 ||
        bus.voiceLoad_o !== 4'b0 || vn(1) !== 8'd62) begin
      $display("FAIL off: gate=%b cnt=%0d load=%b v1=%0d (want 1101 3 0000 62)",
               bus.voiceGate_o, bus.activeCnt_o, bus.voiceLoad_o, vn(1));
      errors++;
    end
    noteOff(8'd99);
    checks++;
    if (bus.voiceGate_o !== 4'b1101 || bus.activeCnt_o !== 3'd3 ||
        bus.voiceNote_o !== {8'd65, 8'd64, 8'd62, 8'd67}) begin
      $display("FAIL off_nomatch: gate=%b cnt=%0d notes=%h (want 1101 3 41403e43)",
               bus.voiceGate_o, bus.activeCnt_o, bus.voiceNote_o);
      errors++;
    end
    noteOn(8'd70);
    checks++;
    if (bus.voiceLoad_o !== 4'b0010 || bus.steal_o !== 1'b0 ||
        vn(1) !== 8'd70 || bus.activeCnt_o !== 3'd4) begin
      $display("FAIL realloc: load=%b steal=%b v1=%0d cnt=%0d (want 0010 0 70 4)",
               bus.voiceLoad_o, bus.steal_o, vn(1), bus.activeCnt_o);
      errors++;
    end
  endtask

  task automatic test_on_off_same;
    @(negedge clk);
    bus.note_i = 8'd60;
    bus.noteOnStrb_i = 1'b1;
    bus.noteOffStrb_i = 1'b1;
    @(negedge clk);
    bus.noteOnStrb_i = 1'b0;
    bus.noteOffStrb_i = 1'b0;
    checks++;
    if (bus.voiceGate_o !== 4'b0001 || vn(0) !== 8'd60 ||
        bus.voiceLoad_o !== 4'b0001 || bus.activeCnt_o !== 3'd1) begin
      $display("FAIL on_off: gate=%b v0=%0d load=%b cnt=%0d (want 0001 60 0001 1)",
               bus.voiceGate_o, vn(0), bus.voiceLoad_o, bus.activeCnt_o);
      errors++;
    end
  endtask

  task automatic test_async_reset;
    noteOn(8'd50);
    noteOn(8'd52);
    #2 rstN = 1'b0;
    #1;
    checks++;
    if (bus.voiceGate_o !== 4'b0 || bus.voiceNote_o !== 32'h0 ||
        bus.activeCnt_o !== 3'd0 || bus.voiceLoad_o !== 4'b0) begin
      $display("FAIL async_rst: gate=%b notes=%h cnt=%0d load=%b (want 0)",
               bus.voiceGate_o, bus.voiceNote_o, bus.activeCnt_o,
               bus.voiceLoad_o);
      errors++;
    end
    @(negedge clk);
    rstN = 1'b1;
    noteOn(8'd80);
    checks++;
    if (bus.voiceLoad_o !== 4'b0001 || vn(0) !== 8'd80) begin
      $display("FAIL post_rst: load=%b v0=%0d (want 0001 80)",
               bus.voiceLoad_o, vn(0));
      errors++;
    end
    noteOn(8'd81);
    noteOn(8'd82);
    noteOn(8'd83);
    noteOn(8'd84);
    checks++;
    if (bus.voiceLoad_o !== 4'b0001 || bus.steal_o !== 1'b1 ||
        vn(0) !== 8'd84) begin
      $display("FAIL post_rst_lru: load=%b steal=%b v0=%0d (want 0001 1 84)",
               bus.voiceLoad_o, bus.steal_o, vn(0));
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_retrigger();
    test_reset();
    test_steal();
    test_release();
    test_reset();
    test_on_off_same();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
